vend_change_dispenser: RTL
==========================

Name: vend_change_dispenser

Overview:
- Output-side counterpart of the vending coin-acceptor FSM: takes a change amount in cents and dispenses it as quarters, dimes and nickels, one coin at a time.
- Selection is greedy (largest coin first).
- Each coin is handed to the payout mechanism over a level/ack handshake.
- Sits between the credit/price arithmetic (source of amount_i and start_i) and the coin-ejector drivers.

Parameters:
- AMT_W, 8, width of amount_i and remain_o in cents.
- TIMEOUT_CYC, 255, max cycles a coin request may wait for coin_ack_i before abort.
- INV_W, 6, width of per-coin inventory counters; used only with CHANGE_INVENTORY_EN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- start_i  in  1  request to dispense amount_i; sampled only in IDLE
- amount_i  in  AMT_W  change owed in cents
- coin_ack_i  in  1  mechanism has ejected the currently requested coin
- quarter_o  out  1  request 25c coin
- dime_o  out  1  request 10c coin
- nickel_o  out  1  request 5c coin
- busy_o  out  1  transaction in progress
- done_o  out  1  one-cycle end-of-transaction pulse
- err_o  out  1  valid with done_o: transaction failed
- remain_o  out  AMT_W  cents still owed
- load_q_i / load_d_i / load_n_i  in  1 each  add one coin to inventory (present only with CHANGE_INVENTORY_EN)

Interface decision: reset rst_ni, asynchronous, active-low; clock clk_i.

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE.
  - All outputs 0: coin outputs, busy_o, done_o, err_o, remain_o.
  - Timeout counter 0; inventory counters 0.
  - Reset mid-transaction drops coin requests immediately; no done_o is produced.
- States: IDLE, SELECT, ISSUE, DONE. All outputs are registered.
- IDLE:
  - start_i=1: remain_o<=amount_i, err flag<=(amount_i mod 5 != 0).
  - Go to DONE if amount_i==0 or amount_i is invalid; otherwise go to SELECT.
- SELECT (1 cycle, busy_o=1):
  - remain>=25 -> quarter; else remain>=10 -> dime; else nickel.
  - Next state ISSUE, with exactly one coin output asserted (one-hot). Timeout counter cleared.
- ISSUE (busy_o=1):
  - The coin output is held until coin_ack_i is sampled 1.
  - On the ack cycle: remain_o<=remain_o-coin_value and the coin output deasserts next cycle. Next state is DONE if the new remain is 0, else SELECT.
  - coin_ack_i is ignored in all other states.
  - If TIMEOUT_CYC cycles elapse without ack: deassert coin, set err, go to DONE. remain_o is not decremented.
- DONE: done_o=1 for one cycle, err_o=err flag, busy_o=0, then IDLE.
- done_o/err_o are 0 outside DONE. remain_o holds its value until the next accepted start_i.
- start_i outside IDLE is ignored.
- Latency: start at cycle 0 -> SELECT in cycle 1 -> first coin asserted in cycle 2. Ack in cycle k -> next coin asserted in cycle k+2.
- Zero/invalid amount: done_o in cycle 1, no coin output ever asserted.
- Arithmetic: the subtraction never underflows because a coin is selected only if coin_value<=remain.

Optional Feature:
- Macro: CHANGE_INVENTORY_EN.
- Defined:
  - Ports load_q_i, load_d_i, load_n_i exist.
  - Three INV_W counters, each +1 on its load pulse (saturating) and -1 on ack of that coin. Simultaneous load and ack of the same coin leaves the count unchanged.
  - SELECT chooses the largest coin with value<=remain and count>0.
  - If no coin is eligible while remain>0: set err, go to DONE; remain_o shows the unpaid amount.
- Undefined: load ports absent, supply unlimited, no inventory errors.

Test Plan:
1. start_i with amount_i=65, ack 1 cycle after each request -> coins quarter, quarter, dime, nickel; remain_o 40, 15, 5, 0; done_o=1, err_o=0.
2. amount_i=0 -> done_o in cycle 1 with err_o=0; no coin output asserted.
3. amount_i=7 -> done_o in cycle 1 with err_o=1; remain_o=7; no coin asserted.
4. amount_i=30, coin_ack_i held 0 -> quarter_o high for TIMEOUT_CYC cycles, then dropped; done_o with err_o=1, remain_o=30.
5. start_i pulsed during ISSUE -> ignored, transaction unchanged. rst_ni low in ISSUE -> all outputs 0 asynchronously; a new start_i after reset completes normally.
6. CHANGE_INVENTORY_EN, loads 1 quarter / 0 dimes / 10 nickels, amount 40 -> quarter + 3 nickels, err_o=0. Then amount 30 with 0 quarters / 0 dimes / 2 nickels -> 2 nickels, then done_o, err_o=1, remain_o=20.

Source files
------------

// File: rtl/vend_change_dispenser.sv
// rtl/vend_change_dispenser.sv - greedy quarter/dime/nickel change dispenser with ack handshake
//
// Pays out amount_i cents one coin at a time, largest coin first. Each coin
// request is held until the ejector acknowledges it or TIMEOUT_CYC cycles pass.
// Optional macro CHANGE_INVENTORY_EN adds per-coin inventory counters and the
// load_q_i/load_d_i/load_n_i ports; with it undefined the supply is unlimited.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   start_i, amount_i       begin dispensing amount_i cents (sampled in IDLE only)
//   coin_ack_i              ejector has delivered the requested coin
//   quarter_o/dime_o/nickel_o  one-hot coin request (registered)
//   busy_o                  transaction in progress
//   done_o, err_o           one-cycle completion pulse and its failure flag
//   remain_o                cents still owed
//   load_q_i/load_d_i/load_n_i  add one coin to inventory (CHANGE_INVENTORY_EN only)

module vend_change_dispenser #(
  parameter int AMT_W       = 8,
  parameter int TIMEOUT_CYC = 255,
  parameter int INV_W       = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic             coin_ack_i,
`ifdef CHANGE_INVENTORY_EN
  input  logic             load_q_i,
  input  logic             load_d_i,
  input  logic             load_n_i,
`endif
  output logic             quarter_o,
  output logic             dime_o,
  output logic             nickel_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [AMT_W-1:0] remain_o
);

  // Counter must hold TIMEOUT_CYC-1, the value at which the request is abandoned.
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [AMT_W-1:0] VAL_Q = AMT_W'(25);
  localparam logic [AMT_W-1:0] VAL_D = AMT_W'(10);
  localparam logic [AMT_W-1:0] VAL_N = AMT_W'(5);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remain_q, remain_d;
  logic             err_q, err_d;
  logic [2:0]       coin_q, coin_d;      // {quarter, dime, nickel}
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             erro_q, erro_d;
  logic [AMT_W-1:0] coin_val;
  logic             ok_q, ok_d, ok_n;    // coin kinds currently allowed
  logic [2:0]       ack_coin;

  assign coin_val = coin_q[2] ? VAL_Q : (coin_q[1] ? VAL_D : VAL_N);
  // Only an ack during ISSUE consumes a coin.
  assign ack_coin = (state_q == ST_ISSUE && coin_ack_i) ? coin_q : 3'b000;

`ifdef CHANGE_INVENTORY_EN
  logic [INV_W-1:0] inv_q_q, inv_q_d;
  logic [INV_W-1:0] inv_d_q, inv_d_d;
  logic [INV_W-1:0] inv_n_q, inv_n_d;

  // Load saturates at all-ones; load and ack together cancel out.
  function automatic logic [INV_W-1:0] inv_next(input logic [INV_W-1:0] cnt,
                                                input logic ld, input logic ak);
    logic [INV_W-1:0] r;
    r = cnt;
    if (ld && !ak && cnt != {INV_W{1'b1}}) r = cnt + INV_W'(1);
    else if (!ld && ak && cnt != '0)       r = cnt - INV_W'(1);
    return r;
  endfunction

  always_comb begin
    inv_q_d = inv_next(inv_q_q, load_q_i, ack_coin[2]);
    inv_d_d = inv_next(inv_d_q, load_d_i, ack_coin[1]);
    inv_n_d = inv_next(inv_n_q, load_n_i, ack_coin[0]);
  end

  assign ok_q = (inv_q_q != '0);
  assign ok_d = (inv_d_q != '0);
  assign ok_n = (inv_n_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inv_q_q <= '0;
      inv_d_q <= '0;
      inv_n_q <= '0;
    end else begin
      inv_q_q <= inv_q_d;
      inv_d_q <= inv_d_d;
      inv_n_q <= inv_n_d;
    end
  end
`else
  assign ok_q = 1'b1;
  assign ok_d = 1'b1;
  assign ok_n = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    err_d    = err_q;
    coin_d   = coin_q;
    tmo_d    = tmo_q;

    unique case (state_q)
      ST_IDLE: begin
        coin_d = 3'b000;
        if (start_i) begin
          remain_d = amount_i;
          err_d    = ((amount_i % VAL_N) != '0);
          if (amount_i == '0 || (amount_i % VAL_N) != '0) state_d = ST_DONE;
          else                                             state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        tmo_d   = '0;
        state_d = ST_ISSUE;
        // remain is a non-zero multiple of 5 here, so a nickel always fits.
        if (remain_q >= VAL_Q && ok_q)      coin_d = 3'b100;
        else if (remain_q >= VAL_D && ok_d) coin_d = 3'b010;
        else if (ok_n)                      coin_d = 3'b001;
        else begin
          coin_d  = 3'b000;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (coin_ack_i) begin
          remain_d = remain_q - coin_val;
          coin_d   = 3'b000;
          state_d  = (remain_d == '0) ? ST_DONE : ST_SELECT;
        end else if (tmo_q == TMO_LAST) begin
          coin_d  = 3'b000;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE: begin
        coin_d  = 3'b000;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the upcoming state.
    busy_d = (state_d == ST_SELECT) || (state_d == ST_ISSUE);
    done_d = (state_d == ST_DONE);
    erro_d = (state_d == ST_DONE) && err_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      err_q    <= 1'b0;
      coin_q   <= 3'b000;
      tmo_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      err_q    <= err_d;
      coin_q   <= coin_d;
      tmo_q    <= tmo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      erro_q   <= erro_d;
    end
  end

  assign quarter_o = coin_q[2];
  assign dime_o    = coin_q[1];
  assign nickel_o  = coin_q[0];
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = erro_q;
  assign remain_o  = remain_q;

endmodule
